vram_port: RTL and testbench
============================

Name: vram_port

Overview:
- Responder side of the display's screen-memory read interface.
- Owns the 8K x 16 screen RAM. Answers display read requests with a fixed 3-cycle latency.
- Accepts CPU screen writes (Hack screen map, word-addressed 0..8191) through a small write buffer. Writes drain into RAM on cycles the display leaves the RAM port free.
- Provides a hardware screen-clear engine. Sits between the CPU memory-map decode and the VGA scan-out block.

Parameters:
- ADDR_W, 13, word address width (8192 words)
- DATA_W, 16, word width; bit 0 = leftmost pixel of the word
- WBUF_DEPTH, 4, CPU write buffer entries (power of two)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vram_rden  in  1  display read request, sampled on rising clk
- vram_raddr  in  ADDR_W  display read address, sampled with vram_rden
- vram_rdata  out  DATA_W  read data for the request made 3 edges earlier
- cpu_we  in  1  CPU write strobe; accepted when cpu_we && cpu_ready
- cpu_addr  in  ADDR_W  CPU write word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  write buffer not full
- clear_req  in  1  one-cycle pulse: start whole-screen clear to 0
- clear_busy  out  1  clear engine active

Behaviour:
- Reset (async, active-high) clears the following:
  - vram_rdata=0, cpu_ready=1, clear_busy=0.
  - Write buffer empty; pipeline valid bits 0; FSM=IDLE.
  - RAM contents are not reset.
- Read pipeline, fixed and never stalled:
  - E1: the edge sampling vram_rden=1 captures raddr into stage-1.
  - E2: the RAM port performs the synchronous read of the stage-1 address.
  - E3: RAM output is registered into vram_rdata.
  - vram_rdata holds its value until the next completed read.
  - Back-to-back reads are allowed every cycle.
- RAM port arbitration, one access per edge, priority: display read > clear write > buffered CPU write.
  - A slot is free on any edge where stage-1 is not valid.
- Write buffer: FIFO of {addr,data}, WBUF_DEPTH entries.
  - cpu_ready = !full.
  - Push and pop on the same edge are allowed; occupancy is unchanged.
  - Push while full is dropped (CPU must honour cpu_ready).
  - Pop happens only on a free slot and only in IDLE.
- Hazard: a display read of an address with a write still buffered returns the old data; no forwarding. A write and a read of the same address never occupy the same edge.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req; the clear counter is set to 0 and clear_busy=1 from the next cycle.
  - In CLEAR, each free slot writes 0 to address counter and increments the counter.
  - Counter == 2^ADDR_W-1 written -> IDLE, clear_busy=0.
  - clear_req while in CLEAR is ignored (no restart).
  - CPU writes are still accepted during CLEAR until the buffer is full. They drain after CLEAR, so they land on the cleared screen.
- Reset mid-clear: immediate IDLE; RAM is left partially cleared; no resume.
- Counter arithmetic is ADDR_W bits and unsigned; no wrap beyond the final address.

Decomposition:
- Shared package holds:
  - SCREEN_WORDS=8192, SCREEN_ADDR_W=13, SCREEN_DATA_W=16
  - VRAM_READ_LATENCY=3 (shared with the VGA block's prefetch timing)
  - FSM state enum {ST_IDLE, ST_CLEAR}
- Sub-modules:
  - vram_wbuf: synchronous FIFO with full/empty flags.
  - The RAM array is a single-port synchronous block inferred in-module.

Test Plan:
- Write 0xA5A5 to addr 100 via CPU with the display idle, then read addr 100 -> vram_rdata=0xA5A5 exactly 3 edges after the read sample, not at edge 2.
- Read every cycle for 64 cycles (addrs 0..63, preloaded with data=addr) -> vram_rdata sequence 0..63 with constant 3-cycle lag; no bubbles.
- Display reads every cycle while the CPU pushes 5 writes -> cpu_ready drops after the 4th push; 5th push dropped; all 4 land once reads pause; stored values correct.
- Buffered write to addr 7 (0x1234, old 0xFFFF), display reads addr 7 before drain -> returns 0xFFFF; after drain, read returns 0x1234.
- Fill RAM with 0xFFFF, pulse clear_req, no reads -> clear_busy high for 8192 cycles; all words read 0; a second clear_req mid-clear has no effect.
- Assert reset at clear counter 4000 -> clear_busy=0, vram_rdata=0 immediately (async); addr 3999 reads 0; addr 4001 reads 0xFFFF.

Source files
------------

// File: rtl/vram_port_pkg.sv
// Shared screen-memory constants and the clear-engine state type.
// VRAM_READ_LATENCY is also used by the VGA block for its prefetch timing.
package vram_port_pkg;
  localparam int SCREEN_WORDS      = 8192;
  localparam int SCREEN_ADDR_W     = 13;
  localparam int SCREEN_DATA_W     = 16;
  localparam int VRAM_READ_LATENCY = 3;

  typedef enum logic {ST_IDLE, ST_CLEAR} vram_state_e;
endpackage

// File: rtl/vram_wbuf.sv
// CPU write buffer: small synchronous FIFO of {addr,data} with full/empty flags.
// A push while full is dropped, even if a pop happens on the same edge.
module vram_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 13,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_addr   = r_mem[r_rdPtr][AW+DW-1:DW];
  assign o_data   = r_mem[r_rdPtr][DW-1:0];

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= {i_addr, i_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/vram_port.sv
// Screen RAM responder: fixed-latency display reads, buffered CPU writes and a
// whole-screen clear engine sharing one single-port RAM.
module vram_port
  import vram_port_pkg::*;
#(
  parameter int ADDR_W     = SCREEN_ADDR_W,
  parameter int DATA_W     = SCREEN_DATA_W,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vram_rden,
  input  logic [ADDR_W-1:0] vram_raddr,
  output logic [DATA_W-1:0] vram_rdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  input  logic              clear_req,
  output logic              clear_busy
);
  localparam int RAM_WORDS = 2 ** ADDR_W;
  localparam int STAGES    = VRAM_READ_LATENCY - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [DATA_W-1:0] r_mem [RAM_WORDS];
  logic [DATA_W-1:0] r_ramQ;
  logic [DATA_W-1:0] r_rdata;
  logic [STAGES-1:0] r_pipeValid;
  logic [ADDR_W-1:0] r_s1Addr;
  logic [ADDR_W-1:0] r_clrCnt;
  vram_state_e       r_state;
  vram_state_e       w_nextState;

  logic              w_slotFree;
  logic              w_ramWe;
  logic [ADDR_W-1:0] w_ramAddr;
  logic [DATA_W-1:0] w_ramWdata;
  logic              w_pop;
  logic              w_clrAdvance;
  logic [ADDR_W-1:0] w_wbAddr;
  logic [DATA_W-1:0] w_wbData;
  logic              w_wbFull;
  logic              w_wbEmpty;

  vram_wbuf #(.DEPTH(WBUF_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (cpu_we),
    .i_addr  (cpu_addr),
    .i_data  (cpu_wdata),
    .i_pop   (w_pop),
    .o_addr  (w_wbAddr),
    .o_data  (w_wbData),
    .o_full  (w_wbFull),
    .o_empty (w_wbEmpty)
  );

  assign cpu_ready  = !w_wbFull;
  assign clear_busy = (r_state == ST_CLEAR);
  assign vram_rdata = r_rdata;
  assign w_slotFree = !r_pipeValid[0];

  // A pending display read owns the RAM port; clears beat buffered CPU writes.
  always_comb begin
    w_nextState  = r_state;
    w_ramWe      = 1'b0;
    w_ramAddr    = r_s1Addr;
    w_ramWdata   = '0;
    w_pop        = 1'b0;
    w_clrAdvance = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) w_nextState = ST_CLEAR;
        if (w_slotFree && !w_wbEmpty) begin
          w_pop      = 1'b1;
          w_ramWe    = 1'b1;
          w_ramAddr  = w_wbAddr;
          w_ramWdata = w_wbData;
        end
      end
      ST_CLEAR: begin
        if (w_slotFree) begin
          w_ramWe      = 1'b1;
          w_ramAddr    = r_clrCnt;
          w_clrAdvance = 1'b1;
          if (r_clrCnt == LAST_ADDR) w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_clrCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && clear_req)
        r_clrCnt <= '0;
      else if (w_clrAdvance && r_clrCnt != LAST_ADDR)
        r_clrCnt <= r_clrCnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipeValid <= '0;
      r_s1Addr    <= '0;
      r_rdata     <= '0;
    end else begin
      r_pipeValid <= {r_pipeValid[STAGES-2:0], vram_rden};
      if (vram_rden) r_s1Addr <= vram_raddr;
      if (r_pipeValid[STAGES-1]) r_rdata <= r_ramQ;
    end
  end

  // RAM contents survive reset; the control path above keeps it idle during reset.
  always_ff @(posedge clk) begin
    if (w_ramWe)
      r_mem[w_ramAddr] <= w_ramWdata;
    else if (r_pipeValid[0])
      r_ramQ <= r_mem[w_ramAddr];
  end
endmodule

// File: tb/tb_vram_port.sv
// Directed self-checking bench for vram_port: read latency, write buffering,
// read/write hazard, screen clear and reset in the middle of a clear.
module tb_vram_port;
  import vram_port_pkg::*;

  logic        clk;
  logic        reset;
  logic        vram_rden;
  logic [12:0] vram_raddr;
  logic [15:0] vram_rdata;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic        clear_req;
  logic        clear_busy;

  int checks = 0;
  int errors = 0;

  vram_port dut (
    .clk        (clk),
    .reset      (reset),
    .vram_rden  (vram_rden),
    .vram_raddr (vram_raddr),
    .vram_rdata (vram_rdata),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .clear_req  (clear_req),
    .clear_busy (clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rd, input logic [12:0] ra, input logic we,
                               input logic [12:0] wa, input logic [15:0] wd, input logic clr);
    vram_rden  = rd;
    vram_raddr = ra;
    cpu_we     = we;
    cpu_addr   = wa;
    cpu_wdata  = wd;
    clear_req  = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpuWrite(input logic [12:0] a, input logic [15:0] d);
    applyStimulus(1'b0, '0, 1'b1, a, d, 1'b0);
    step();
  endtask

  task automatic drain();
    idle();
    repeat (6) step();
  endtask

  task automatic readCheck(input string tag, input logic [12:0] a, input logic [15:0] exp);
    applyStimulus(1'b1, a, 1'b0, '0, '0, 1'b0);
    step();
    idle();
    step();
    step();
    checkOutput(tag, 32'(vram_rdata), 32'(exp));
  endtask

  // Back-to-back reads; the word sampled at one edge must appear two edges later.
  task automatic readRange(input int start, input int n, input bit useConst,
                           input logic [15:0] val, output int bad);
    logic [15:0] e;
    bad = 0;
    for (int j = 0; j < n + 2; j++) begin
      applyStimulus(j < n, 13'(start + j), 1'b0, '0, '0, 1'b0);
      step();
      if (j >= 2) begin
        e = useConst ? val : 16'(start + j - 2);
        if (vram_rdata !== e) bad++;
      end
    end
    idle();
  endtask

  initial begin
    int bad;
    int busyCycles;

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    checkOutput("reset_rdata", 32'(vram_rdata), 32'h0);
    checkOutput("reset_ready", 32'(cpu_ready), 32'h1);
    checkOutput("reset_busy", 32'(clear_busy), 32'h0);
    reset = 1'b0;
    step();

    $display("[TB] single write then read latency");
    cpuWrite(13'd100, 16'hA5A5);
    drain();
    applyStimulus(1'b1, 13'd100, 1'b0, '0, '0, 1'b0);
    step();
    idle();
    step();
    checkOutput("lat_edge2", 32'(vram_rdata), 32'h0);
    step();
    checkOutput("lat_edge3", 32'(vram_rdata), 32'hA5A5);

    $display("[TB] streaming reads 0..63");
    for (int a = 0; a < 64; a++) cpuWrite(13'(a), 16'(a));
    drain();
    readRange(0, 64, 1'b0, '0, bad);
    checkOutput("stream_bad", 32'(bad), 32'h0);

    $display("[TB] write buffer fills under continuous reads");
    cpuWrite(13'd204, 16'hDEAD);
    drain();
    applyStimulus(1'b1, '0, 1'b0, '0, '0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("ready_before_push%0d", i), 32'(cpu_ready), (i < 4) ? 32'h1 : 32'h0);
      applyStimulus(1'b1, '0, 1'b1, 13'(200 + i), 16'(16'h0C00 + i), 1'b0);
      step();
    end
    checkOutput("ready_after_5th", 32'(cpu_ready), 32'h0);
    drain();
    checkOutput("ready_after_drain", 32'(cpu_ready), 32'h1);
    readCheck("buf_200", 13'd200, 16'h0C00);
    readCheck("buf_201", 13'd201, 16'h0C01);
    readCheck("buf_202", 13'd202, 16'h0C02);
    readCheck("buf_203", 13'd203, 16'h0C03);
    readCheck("dropped_204", 13'd204, 16'hDEAD);

    $display("[TB] read of an address with a buffered write");
    cpuWrite(13'd7, 16'hFFFF);
    drain();
    applyStimulus(1'b1, 13'd7, 1'b0, '0, '0, 1'b0);
    step();
    applyStimulus(1'b1, 13'd7, 1'b1, 13'd7, 16'h1234, 1'b0);
    step();
    applyStimulus(1'b1, 13'd7, 1'b0, '0, '0, 1'b0);
    step();
    checkOutput("hazard_old", 32'(vram_rdata), 32'hFFFF);
    drain();
    readCheck("hazard_new", 13'd7, 16'h1234);

    $display("[TB] full screen clear");
    for (int a = 0; a < SCREEN_WORDS; a++) cpuWrite(13'(a), 16'hFFFF);
    drain();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    step();
    idle();
    checkOutput("clear_busy_start", 32'(clear_busy), 32'h1);
    busyCycles = 0;
    while (clear_busy && busyCycles < 9000) begin
      applyStimulus(1'b0, '0, busyCycles == 100, 13'd50, 16'hBEEF, busyCycles == 4000);
      step();
      busyCycles++;
    end
    idle();
    checkOutput("clear_busy_cycles", 32'(busyCycles), 32'd8192);
    drain();
    readRange(0, 50, 1'b1, 16'h0000, bad);
    checkOutput("clear_low_bad", 32'(bad), 32'h0);
    readCheck("write_during_clear", 13'd50, 16'hBEEF);
    readRange(51, SCREEN_WORDS - 51, 1'b1, 16'h0000, bad);
    checkOutput("clear_high_bad", 32'(bad), 32'h0);

    $display("[TB] reset in the middle of a clear");
    for (int a = 0; a < SCREEN_WORDS; a++) cpuWrite(13'(a), 16'hFFFF);
    drain();
    readCheck("prefill_8000", 13'd8000, 16'hFFFF);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    step();
    idle();
    repeat (4000) step();
    checkOutput("busy_before_reset", 32'(clear_busy), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_busy", 32'(clear_busy), 32'h0);
    checkOutput("reset_mid_rdata", 32'(vram_rdata), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    checkOutput("no_resume", 32'(clear_busy), 32'h0);
    readCheck("partial_3999", 13'd3999, 16'h0000);
    readCheck("partial_4000", 13'd4000, 16'hFFFF);
    readCheck("partial_4001", 13'd4001, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
